// File: rtl/counter_cmd_pkg.sv
// Shared types and default sizes for the counter command driver and its expected-value model.
package counter_cmd_pkg;

  localparam int unsigned WIDTH_DEF  = 4;
  localparam int unsigned STEP_W_DEF = 8;

  typedef enum logic [1:0] {
    OP_LOAD = 2'd0,
    OP_UP   = 2'd1,
    OP_DOWN = 2'd2,
    OP_HOLD = 2'd3
  } cmd_op_e;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_DRIVE_LOAD = 3'd1,
    ST_DRIVE_STEP = 3'd2,
    ST_CHECK      = 3'd3,
    ST_RESP       = 3'd4
  } state_e;

endpackage

// File: rtl/counter_exp_model.sv
// Expected-value register for a modulo-2^WIDTH up/down counter with load priority.
module counter_exp_model #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ld,
  input  logic             inc,
  input  logic             dec,
  input  logic [WIDTH-1:0] ld_val,
  output logic [WIDTH-1:0] exp_val
);

  logic [WIDTH-1:0] exp_d;
  logic [WIDTH-1:0] exp_q;

  // Load wins over counting; wrap falls out of the fixed-width add/subtract.
  always_comb begin
    exp_d = exp_q;
    if (ld) begin
      exp_d = ld_val;
    end else if (inc) begin
      exp_d = exp_q + WIDTH'(1);
    end else if (dec) begin
      exp_d = exp_q - WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      exp_q <= '0;
    end else begin
      exp_q <= exp_d;
    end
  end

  assign exp_val = exp_q;

endmodule

// File: rtl/counter_cmd_driver.sv
// Command-driven initiator for a counter: drives load/enable/up_down, then checks data_out
// against an internal expected value and returns the result on a valid/ready response port.
module counter_cmd_driver
  import counter_cmd_pkg::*;
#(
  parameter int unsigned WIDTH  = WIDTH_DEF,
  parameter int unsigned STEP_W = STEP_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [WIDTH-1:0]  cmd_data,
  input  logic [STEP_W-1:0] cmd_steps,
  output logic [WIDTH-1:0]  data_in,
  output logic              load,
  output logic              enable,
  output logic              up_down,
  input  logic [WIDTH-1:0]  data_out,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [WIDTH-1:0]  rsp_data,
  output logic              rsp_err,
  output logic              busy
);

  state_e              state_q, state_d;
  cmd_op_e             op_q, op_d;
  logic [STEP_W-1:0]   step_cnt_q, step_cnt_d;
  logic                cmd_ready_q, cmd_ready_d;
  logic                load_q, load_d;
  logic                enable_q, enable_d;
  logic                up_down_q, up_down_d;
  logic [WIDTH-1:0]    data_in_q, data_in_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0]    rsp_data_q, rsp_data_d;
  logic                rsp_err_q, rsp_err_d;
  logic                busy_q, busy_d;

  logic                exp_ld;
  logic                exp_inc;
  logic                exp_dec;
  logic [WIDTH-1:0]    exp_val;

  // The model advances on the same cycles the counter sees the registered drive.
  assign exp_ld  = (state_q == ST_DRIVE_LOAD);
  assign exp_inc = (state_q == ST_DRIVE_STEP) && (op_q == OP_UP);
  assign exp_dec = (state_q == ST_DRIVE_STEP) && (op_q == OP_DOWN);

  counter_exp_model #(
    .WIDTH (WIDTH)
  ) u_exp_model (
    .clk     (clk),
    .reset   (reset),
    .ld      (exp_ld),
    .inc     (exp_inc),
    .dec     (exp_dec),
    .ld_val  (data_in_q),
    .exp_val (exp_val)
  );

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    step_cnt_d  = step_cnt_q;
    load_d      = 1'b0;
    enable_d    = 1'b0;
    up_down_d   = up_down_q;
    data_in_d   = data_in_q;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;

    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          op_d = cmd_op_e'(cmd_op);
          if (op_d == OP_LOAD) begin
            state_d   = ST_DRIVE_LOAD;
            load_d    = 1'b1;
            data_in_d = cmd_data;
          end else if (cmd_steps == '0) begin
            state_d = ST_CHECK;
          end else begin
            // First step is driven straight out of the accept edge.
            state_d    = ST_DRIVE_STEP;
            step_cnt_d = cmd_steps - STEP_W'(1);
            enable_d   = (op_d != OP_HOLD);
            if (op_d != OP_HOLD) begin
              up_down_d = (op_d == OP_UP);
            end
          end
        end
      end
      ST_DRIVE_LOAD: begin
        state_d = ST_CHECK;
      end
      ST_DRIVE_STEP: begin
        if (step_cnt_q == '0) begin
          state_d = ST_CHECK;
        end else begin
          step_cnt_d = step_cnt_q - STEP_W'(1);
          enable_d   = (op_q != OP_HOLD);
        end
      end
      ST_CHECK: begin
        rsp_data_d = data_out;
        rsp_err_d  = (data_out != exp_val);
        state_d    = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_valid_q && rsp_ready) begin
          state_d = ST_IDLE;
        end else begin
          rsp_valid_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    cmd_ready_d = (state_d == ST_IDLE);
    busy_d      = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      op_q        <= OP_LOAD;
      step_cnt_q  <= '0;
      cmd_ready_q <= 1'b1;
      load_q      <= 1'b0;
      enable_q    <= 1'b0;
      up_down_q   <= 1'b0;
      data_in_q   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      step_cnt_q  <= step_cnt_d;
      cmd_ready_q <= cmd_ready_d;
      load_q      <= load_d;
      enable_q    <= enable_d;
      up_down_q   <= up_down_d;
      data_in_q   <= data_in_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      busy_q      <= busy_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign load      = load_q;
  assign enable    = enable_q;
  assign up_down   = up_down_q;
  assign data_in   = data_in_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign busy      = busy_q;

endmodule

// File: doc/counter_cmd_driver.md
Name: counter_cmd_driver

Overview:
- Hardware initiator for the counter interface: accepts high-level commands over a valid/ready port and drives load/enable/up_down/data_in cycle by cycle.
- Keeps an internal expected-value model, samples data_out after each command, and returns the final value plus a mismatch flag on a response port.
- Sits on the driving side of a counter instance; used both as an on-chip stimulus engine and as a self-checking companion in block tests.

Parameters:
- WIDTH, 4, counter data width; all counter arithmetic is modulo 2^WIDTH.
- STEP_W, 8, width of the step-count field; max steps per command = 2^STEP_W-1.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  block can accept a command.
- cmd_op  input  2  0=LOAD, 1=UP, 2=DOWN, 3=HOLD.
- cmd_data  input  WIDTH  load value (LOAD only).
- cmd_steps  input  STEP_W  number of count/hold cycles (UP/DOWN/HOLD).
- data_in  output  WIDTH  to counter.
- load  output  1  to counter.
- enable  output  1  to counter.
- up_down  output  1  to counter; 1=up, 0=down.
- data_out  input  WIDTH  from counter.
- rsp_valid  output  1  response present.
- rsp_ready  input  1  consumer accepts response.
- rsp_data  output  WIDTH  counter value sampled at CHECK.
- rsp_err  output  1  sampled value != expected.
- busy  output  1  FSM not in IDLE.

Behaviour:
- Counter contract: synchronous; load has priority over enable; data_out updates on the clk edge that samples load/enable; wraps modulo 2^WIDTH both directions.
- All outputs registered. Reset values: cmd_ready=1, load=0, enable=0, up_down=0, data_in=0, rsp_valid=0, rsp_data=0, rsp_err=0, busy=0. Expected model exp=0. Step counter=0.
- FSM states: IDLE, DRIVE_LOAD, DRIVE_STEP, CHECK, RESP.
- IDLE: cmd_ready=1. On cmd_valid && cmd_ready, latch op/data/steps and drop cmd_ready the next cycle.
  - LOAD goes to DRIVE_LOAD.
  - UP/DOWN/HOLD with steps>0 goes to DRIVE_STEP.
  - UP/DOWN/HOLD with steps=0 goes directly to CHECK (pure read).
- DRIVE_LOAD: exactly 1 cycle with load=1, data_in=cmd_data, enable=0. exp<=cmd_data. Next state CHECK.
- DRIVE_STEP: runs exactly cmd_steps cycles.
  - UP/DOWN: enable=1 and up_down=(op==UP); exp<=exp±1 each cycle, with wrap.
  - HOLD: enable=0; exp unchanged.
  - load=0 throughout.
  - After the last step, enable=0 and the FSM goes to CHECK.
- CHECK: 1 cycle. Register rsp_data=data_out and rsp_err=(data_out!=exp). Next state RESP.
- RESP: rsp_valid=1; rsp_data and rsp_err held stable until rsp_ready. On the handshake: rsp_valid=0, go to IDLE, cmd_ready=1 the following cycle.
- Latency from command accept to rsp_valid:
  - LOAD: 3 cycles.
  - UP/DOWN/HOLD: steps+2 cycles.
  - steps=0: 2 cycles.
- No command overlap: cmd_ready=0 whenever busy=1.
- exp persists across commands; only reset or LOAD changes its base.
- Reset asserted mid-operation: immediate return to reset values, FSM to IDLE, pending response discarded, exp=0. The counter's own reset brings it to 0, so the model stays consistent.
- rsp_ready held high while rsp_valid=0 has no effect.

Decomposition:
- Package counter_cmd_pkg holds:
  - typedef enum cmd_op_e {OP_LOAD, OP_UP, OP_DOWN, OP_HOLD};
  - typedef enum state_e for the FSM;
  - default WIDTH/STEP_W localparams.
- One sub-module: counter_exp_model, which holds the exp register with load/inc/dec/hold controls. It isolates the wrap arithmetic for reuse by scoreboards.
- The FSM and port logic stay in the top module.

Test Plan:
- Reset, then LOAD data=4'hA -> load high exactly 1 cycle with data_in=A; rsp_valid at +3 cycles; rsp_data=A, rsp_err=0.
- LOAD 4'hE, then UP steps=3 -> enable high 3 cycles with up_down=1; rsp_data=4'h1 (wrap), rsp_err=0.
- LOAD 4'h1, then DOWN steps=2 -> rsp_data=4'hF (underflow wrap), rsp_err=0.
- HOLD steps=5, then UP steps=0 after value 4'h7 -> enable stays 0; both responses give 4'h7; steps=0 response arrives 2 cycles after accept.
- Hold rsp_ready=0 for 10 cycles during RESP -> rsp_valid, rsp_data and rsp_err stable; cmd_ready=0 throughout; a new cmd_valid is not accepted until after the handshake.
- Assert reset during DRIVE_STEP of UP steps=20 -> all outputs return to reset values asynchronously; no rsp_valid. Then substitute a stuck-at-0 counter and issue LOAD 4'h5 -> rsp_data=0, rsp_err=1.
